// File: rtl/ads1115_i2c_target_pkg.sv
// Shared types and constants for the ADS1115 register-interface I2C target model.
package ads1115_i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT_STOP
    } state_t;

    localparam logic [1:0] PTR_CONV = 2'd0;
    localparam logic [1:0] PTR_CFG  = 2'd1;
    localparam logic [1:0] PTR_LO   = 2'd2;
    localparam logic [1:0] PTR_HI   = 2'd3;

    localparam logic [15:0] LO_THRESH_RST = 16'h8000;
    localparam logic [15:0] HI_THRESH_RST = 16'h7FFF;

endpackage

// File: rtl/ads1115_i2c_target_if.sv
// I2C pin bundle: sampled SCL/SDA levels plus the open-drain SDA pull-down enable.
interface ads1115_i2c_target_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/ads1115_i2c_target_line_cond.sv
// SCL/SDA conditioning: synchronizers, optional majority filter (I2C_GLITCH_FILTER_EN),
// registered SCL edge and START/STOP pulses.
module i2c_line_cond #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic sda_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_lvl;
    logic                   sda_lvl;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_rise_q;
    logic                   scl_fall_q;
    logic                   sda_q;
    logic                   start_q;
    logic                   stop_q;

    // Idle-high reset values keep reset release from looking like a START/STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_win_q;
    logic [1:0] sda_win_q;
    logic       scl_filt_q;
    logic       sda_filt_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_win_q  <= '1;
            sda_win_q  <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_win_q  <= {scl_win_q[0], scl_sync_q[SYNC_STAGES-1]};
            sda_win_q  <= {sda_win_q[0], sda_sync_q[SYNC_STAGES-1]};
            scl_filt_q <= maj3(scl_sync_q[SYNC_STAGES-1], scl_win_q[0], scl_win_q[1]);
            sda_filt_q <= maj3(sda_sync_q[SYNC_STAGES-1], sda_win_q[0], sda_win_q[1]);
        end
    end

    assign scl_lvl = scl_filt_q;
    assign sda_lvl = sda_filt_q;
`else
    assign scl_lvl = scl_sync_q[SYNC_STAGES-1];
    assign sda_lvl = sda_sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            sda_q      <= 1'b1;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_hist_q <= scl_lvl;
            sda_hist_q <= sda_lvl;
            scl_rise_q <= scl_lvl & ~scl_hist_q;
            scl_fall_q <= ~scl_lvl & scl_hist_q;
            sda_q      <= sda_lvl;
            start_q    <= scl_lvl & scl_hist_q & sda_hist_q & ~sda_lvl;
            stop_q     <= scl_lvl & scl_hist_q & ~sda_hist_q & sda_lvl;
        end
    end

    assign scl_rise_o = scl_rise_q;
    assign scl_fall_o = scl_fall_q;
    assign sda_o      = sda_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/ads1115_i2c_target.sv
// ADS1115-compatible I2C target: pointer/config/threshold registers, snapshot reads of conversion data.
// Optional I2C_GLITCH_FILTER_EN adds a majority filter inside i2c_line_cond.
module ads1115_i2c_target
    import ads1115_i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR    = 7'b1001000,
    parameter logic [15:0] CFG_RESET   = 16'h8583,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ads1115_i2c_target_if.slave  bus,
    input  logic [15:0]          conv_data,
    input  logic                 conv_busy,
    output logic                 conv_start,
    output logic [15:0]          cfg_reg,
    output logic [15:0]          lo_thresh,
    output logic [15:0]          hi_thresh,
    output logic                 addr_hit
);

    logic scl_rise, scl_fall, sda, start, stop;

    i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line_cond (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (bus.scl_i),
        .sda_i      (bus.sda_i),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .sda_o      (sda),
        .start_o    (start),
        .stop_o     (stop)
    );

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  msb_q, msb_d;
    logic [15:0] snap_q, snap_d;
    logic        rd_lsb_q, rd_lsb_d;
    logic        mack_q, mack_d;
    logic        sda_oe_q, sda_oe_d;
    logic [15:0] cfg_q, cfg_d;
    logic [15:0] lo_q, lo_d;
    logic [15:0] hi_q, hi_d;
    logic        conv_start_q, conv_start_d;
    logic        addr_hit_q, addr_hit_d;

    logic [15:0] read_reg;
    logic [15:0] wr_word;
    logic [7:0]  rd_byte;
    logic [2:0]  bit_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            ptr_q        <= PTR_CONV;
            byte_idx_q   <= '0;
            msb_q        <= '0;
            snap_q       <= '0;
            rd_lsb_q     <= 1'b0;
            mack_q       <= 1'b1;
            sda_oe_q     <= 1'b0;
            cfg_q        <= CFG_RESET;
            lo_q         <= LO_THRESH_RST;
            hi_q         <= HI_THRESH_RST;
            conv_start_q <= 1'b0;
            addr_hit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            ptr_q        <= ptr_d;
            byte_idx_q   <= byte_idx_d;
            msb_q        <= msb_d;
            snap_q       <= snap_d;
            rd_lsb_q     <= rd_lsb_d;
            mack_q       <= mack_d;
            sda_oe_q     <= sda_oe_d;
            cfg_q        <= cfg_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            conv_start_q <= conv_start_d;
            addr_hit_q   <= addr_hit_d;
        end
    end

    always_comb begin
        case (ptr_q)
            PTR_CONV: read_reg = conv_data;
            PTR_CFG:  read_reg = {~conv_busy, cfg_q[14:0]};
            PTR_LO:   read_reg = lo_q;
            default:  read_reg = hi_q;
        endcase
    end

    assign wr_word = {msb_q, shreg_q};
    assign rd_byte = rd_lsb_q ? snap_q[7:0] : snap_q[15:8];
    assign bit_idx = 3'd7 - bit_cnt_q[2:0];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        ptr_d        = ptr_q;
        byte_idx_d   = byte_idx_q;
        msb_d        = msb_q;
        snap_d       = snap_q;
        rd_lsb_d     = rd_lsb_q;
        mack_d       = mack_q;
        sda_oe_d     = sda_oe_q;
        cfg_d        = cfg_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        conv_start_d = 1'b0;
        addr_hit_d   = 1'b0;

        // Bus conditions override any SCL edge seen in the same cycle.
        if (stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else if (start) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else begin
            if (scl_rise) begin
                case (state_q)
                    ADDR, PTR, WDATA: begin
                        if (bit_cnt_q < 4'd8) begin
                            shreg_d   = {shreg_q[6:0], sda};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                    RDATA:     if (bit_cnt_q < 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
                    RDATA_ACK: mack_d = sda;
                    default: ;
                endcase
            end
            if (scl_fall) begin
                case (state_q)
                    ADDR: begin
                        if (bit_cnt_q == 4'd8) begin
                            if (shreg_q[7:1] == I2C_ADDR) begin
                                state_d    = ADDR_ACK;
                                sda_oe_d   = 1'b1;
                                addr_hit_d = 1'b1;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt_d = '0;
                        if (shreg_q[0]) begin
                            state_d  = RDATA;
                            snap_d   = read_reg;
                            rd_lsb_d = 1'b0;
                            sda_oe_d = ~read_reg[15];
                        end else begin
                            state_d  = PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                    PTR: begin
                        if (bit_cnt_q == 4'd8) begin
                            ptr_d    = shreg_q[1:0];
                            sda_oe_d = 1'b1;
                            state_d  = PTR_ACK;
                        end
                    end
                    PTR_ACK: begin
                        sda_oe_d   = 1'b0;
                        state_d    = WDATA;
                        bit_cnt_d  = '0;
                        byte_idx_d = '0;
                    end
                    WDATA: begin
                        if (bit_cnt_q == 4'd8) begin
                            if (byte_idx_q < 2'd2) begin
                                sda_oe_d = 1'b1;
                                state_d  = WDATA_ACK;
                                if (byte_idx_q == 2'd0) msb_d = shreg_q;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end
                    end
                    WDATA_ACK: begin
                        sda_oe_d   = 1'b0;
                        bit_cnt_d  = '0;
                        state_d    = WDATA;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd1) begin
                            case (ptr_q)
                                PTR_CFG: begin
                                    cfg_d        = {1'b0, wr_word[14:0]};
                                    conv_start_d = wr_word[15];
                                end
                                PTR_LO:  lo_d = wr_word;
                                PTR_HI:  hi_d = wr_word;
                                default: ;
                            endcase
                        end
                    end
                    RDATA: begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = RDATA_ACK;
                        end else begin
                            sda_oe_d = ~rd_byte[bit_idx];
                        end
                    end
                    RDATA_ACK: begin
                        if (!mack_q) begin
                            rd_lsb_d  = ~rd_lsb_q;
                            bit_cnt_d = '0;
                            state_d   = RDATA;
                            sda_oe_d  = ~(rd_lsb_q ? snap_q[15] : snap_q[7]);
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign conv_start = conv_start_q;
    assign cfg_reg    = cfg_q;
    assign lo_thresh  = lo_q;
    assign hi_thresh  = hi_q;
    assign addr_hit   = addr_hit_q;

endmodule

// File: tb/tb_ads1115_i2c_target.sv
// Directed bench for ads1115_i2c_target: bit-banged I2C master on a wired-AND SDA line.
module tb_ads1115_i2c_target;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        spike_once = 1'b0;
    logic [15:0] conv_data = 16'h0000;
    logic        conv_busy = 1'b0;
    logic        conv_start;
    logic [15:0] cfg_reg, lo_thresh, hi_thresh;
    logic        addr_hit;

    int n_checks = 0;
    int n_errors = 0;
    int n_hit = 0;
    int n_cs = 0;
    int n_oe = 0;

    ads1115_i2c_target_if bif();
    assign bif.scl_i = scl_m;
    assign bif.sda_i = sda_m & ~bif.sda_oe;

    ads1115_i2c_target #(
        .I2C_ADDR    (7'b1001000),
        .CFG_RESET   (16'h8583),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bif),
        .conv_data  (conv_data),
        .conv_busy  (conv_busy),
        .conv_start (conv_start),
        .cfg_reg    (cfg_reg),
        .lo_thresh  (lo_thresh),
        .hi_thresh  (hi_thresh),
        .addr_hit   (addr_hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (addr_hit)   n_hit <= n_hit + 1;
        if (conv_start) n_cs  <= n_cs + 1;
        if (bif.sda_oe) n_oe  <= n_oe + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(10);
        scl_m = 1'b1; tick(10);
        sda_m = 1'b0; tick(10);
        scl_m = 1'b0; tick(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(10);
        scl_m = 1'b1; tick(10);
        sda_m = 1'b1; tick(10);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;
        tick(5);
        if (spike_once) begin
            scl_m = 1'b1; tick(1);
            scl_m = 1'b0;
            spike_once = 1'b0;
        end
        tick(5);
        scl_m = 1'b1; tick(20);
        scl_m = 1'b0; tick(10);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(10);
        scl_m = 1'b1; tick(10);
        b = bif.sda_i;
        tick(10);
        scl_m = 1'b0; tick(10);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    initial begin
        logic       a;
        logic       b;
        logic [7:0] d;
        int         h0, c0, o0;

        tick(4);
        check("rst_sda_oe", 32'(bif.sda_oe), 32'd0);
        check("rst_conv_start", 32'(conv_start), 32'd0);
        check("rst_addr_hit", 32'(addr_hit), 32'd0);
        check("rst_cfg", 32'(cfg_reg), 32'h8583);
        check("rst_lo", 32'(lo_thresh), 32'h8000);
        check("rst_hi", 32'(hi_thresh), 32'h7FFF);
        rst_n = 1'b1;
        tick(10);

        // Config write with OS=1
        h0 = n_hit; c0 = n_cs;
        i2c_start();
        wr_byte(8'h90, a); check("t1_ack_addr", 32'(a), 32'd0);
        wr_byte(8'h01, a); check("t1_ack_ptr", 32'(a), 32'd0);
        wr_byte(8'hC4, a); check("t1_ack_msb", 32'(a), 32'd0);
        wr_byte(8'h83, a); check("t1_ack_lsb", 32'(a), 32'd0);
        i2c_stop();
        tick(5);
        check("t1_cfg", 32'(cfg_reg), 32'h4483);
        check("t1_conv_start_cnt", n_cs - c0, 32'd1);
        check("t1_addr_hit_cnt", n_hit - h0, 32'd1);

        // Pointer set then conversion read
        conv_data = 16'h1234;
        i2c_start();
        wr_byte(8'h90, a); check("t2_ack_addr_w", 32'(a), 32'd0);
        wr_byte(8'h00, a); check("t2_ack_ptr", 32'(a), 32'd0);
        i2c_stop();
        i2c_start();
        wr_byte(8'h91, a); check("t2_ack_addr_r", 32'(a), 32'd0);
        rd_byte(d, 1'b0); check("t2_msb", 32'(d), 32'h12);
        rd_byte(d, 1'b1); check("t2_lsb", 32'(d), 32'h34);
        tick(5);
        check("t2_released", 32'(bif.sda_oe), 32'd0);
        i2c_stop();

        // Foreign address
        o0 = n_oe; h0 = n_hit;
        i2c_start();
        wr_byte(8'h92, a); check("t3_nack_addr", 32'(a), 32'd1);
        wr_byte(8'h00, a); check("t3_nack_data", 32'(a), 32'd1);
        i2c_stop();
        tick(5);
        check("t3_oe_cycles", n_oe - o0, 32'd0);
        check("t3_addr_hit_cnt", n_hit - h0, 32'd0);

        // Snapshot coherence across MSB/LSB
        i2c_start();
        wr_byte(8'h91, a); check("t4_ack_addr", 32'(a), 32'd0);
        rd_byte(d, 1'b0); check("t4_msb", 32'(d), 32'h12);
        conv_data = 16'hABCD;
        rd_byte(d, 1'b1); check("t4_lsb", 32'(d), 32'h34);
        i2c_stop();
        i2c_start();
        wr_byte(8'h91, a);
        rd_byte(d, 1'b1); check("t4_new_msb", 32'(d), 32'hAB);
        i2c_stop();

        // Config read with busy flag, repeated START
        conv_busy = 1'b1;
        i2c_start();
        wr_byte(8'h90, a); check("t5_ack_addr_w", 32'(a), 32'd0);
        wr_byte(8'h01, a); check("t5_ack_ptr", 32'(a), 32'd0);
        i2c_start();
        wr_byte(8'h91, a); check("t5_ack_addr_r", 32'(a), 32'd0);
        rd_byte(d, 1'b0); check("t5_busy_msb", 32'(d), 32'h44);
        rd_byte(d, 1'b1); check("t5_busy_lsb", 32'(d), 32'h83);
        i2c_stop();
        conv_busy = 1'b0;
        i2c_start();
        wr_byte(8'h91, a);
        rd_byte(d, 1'b1); check("t5_idle_msb", 32'(d), 32'hC4);
        i2c_stop();

        // Config write with OS=0 wrapping into MSB on read
        c0 = n_cs;
        i2c_start();
        wr_byte(8'h90, a); wr_byte(8'h01, a);
        wr_byte(8'h45, a); wr_byte(8'h83, a);
        i2c_stop();
        tick(5);
        check("cfg_no_os", 32'(cfg_reg), 32'h4583);
        check("cfg_no_os_cs", n_cs - c0, 32'd0);
        i2c_start();
        wr_byte(8'h91, a);
        rd_byte(d, 1'b0); rd_byte(d, 1'b0);
        rd_byte(d, 1'b1); check("read_wrap_msb", 32'(d), 32'hC5);
        i2c_stop();

        // Threshold writes, third data byte NACKed
        i2c_start();
        wr_byte(8'h90, a); wr_byte(8'h02, a);
        wr_byte(8'h12, a); wr_byte(8'h34, a);
        i2c_stop();
        tick(5);
        check("lo_write", 32'(lo_thresh), 32'h1234);
        i2c_start();
        wr_byte(8'h90, a); wr_byte(8'h03, a);
        wr_byte(8'hAB, a); wr_byte(8'hCD, a); check("hi_lsb_ack", 32'(a), 32'd0);
        wr_byte(8'hEF, a); check("third_byte_nack", 32'(a), 32'd1);
        i2c_stop();
        tick(5);
        check("hi_write", 32'(hi_thresh), 32'hABCD);

        // Asynchronous reset mid read-byte (cfg reads 0xC5: bits 1,1,0)
        i2c_start();
        wr_byte(8'h90, a); wr_byte(8'h01, a);
        i2c_stop();
        i2c_start();
        wr_byte(8'h91, a);
        read_bit(b); check("t6_bit7", 32'(b), 32'd1);
        read_bit(b); check("t6_bit6", 32'(b), 32'd1);
        check("t6_driving", 32'(bif.sda_oe), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_sda_oe", 32'(bif.sda_oe), 32'd0);
        check("t6_rst_cfg", 32'(cfg_reg), 32'h8583);
        check("t6_rst_lo", 32'(lo_thresh), 32'h8000);
        check("t6_rst_hi", 32'(hi_thresh), 32'h7FFF);
        scl_m = 1'b1; sda_m = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(10);

`ifdef I2C_GLITCH_FILTER_EN
        i2c_start();
        wr_byte(8'h90, a); wr_byte(8'h02, a);
        spike_once = 1'b1;
        wr_byte(8'h55, a); check("glitch_ack_msb", 32'(a), 32'd0);
        wr_byte(8'hAA, a); check("glitch_ack_lsb", 32'(a), 32'd0);
        i2c_stop();
        tick(5);
        check("glitch_lo", 32'(lo_thresh), 32'h55AA);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
